// File: rtl/cordic_angle_acc.sv
// CORDIC angle accumulator.
// Holds the running angle z of a CORDIC rotation. Each enabled iteration adds
// or subtracts the arctangent constant for the current step. The iteration
// index is exported so that it can address an external atan ROM. Angle wrap
// modulo 2^WIDTH is intended. A separate sticky flag reports signed overflow
// for callers that care about it.
module cordic_angle_acc #(
  parameter int WIDTH      = 32,
  parameter int NITER      = 16,
  parameter int CNT_W      = 5,
  parameter int ZERO_START = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] atan_val_i,
  input  logic [WIDTH-1:0] z_init_i,
  output logic [WIDTH-1:0] z_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index of the final iteration; NITER may be as large as 2^CNT_W.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NITER - 1);

  // Effective addend at WIDTH+1 bits. Negating the most negative atan stays
  // exact here, so it needs no special case.
  function automatic logic signed [WIDTH:0] eff_addend(
    input logic             dir,
    input logic [WIDTH-1:0] atan
  );
    logic signed [WIDTH:0] a_ext;
    a_ext = $signed({atan[WIDTH-1], atan});
    return dir ? a_ext : -a_ext;
  endfunction

  // Exact sum at WIDTH+1 bits; the caller keeps the low WIDTH bits, so the
  // angle wraps.
  function automatic logic signed [WIDTH:0] wide_sum(
    input logic        [WIDTH-1:0] zval,
    input logic signed [WIDTH:0]   addend
  );
    logic signed [WIDTH:0] z_ext;
    z_ext = $signed({zval[WIDTH-1], zval});
    return z_ext + addend;
  endfunction

  // Overflow occurs when both operands share a sign and the wrapped result
  // has the opposite sign.
  function automatic logic sum_ovf(
    input logic        [WIDTH-1:0] zval,
    input logic signed [WIDTH:0]   addend,
    input logic signed [WIDTH:0]   sum
  );
    return (zval[WIDTH-1] == addend[WIDTH]) && (sum[WIDTH-1] != zval[WIDTH-1]);
  endfunction

  state_t                state_q, state_d;
  logic    [WIDTH-1:0]   z_q, z_d;
  logic    [CNT_W-1:0]   iter_q, iter_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic                  step;
  logic                  last;
  logic signed [WIDTH:0] addend;
  logic signed [WIDTH:0] sum_w;

  // An iteration happens only in RUN with en, and only when no start is present.
  assign step   = (state_q == RUN) && en_i && !start_i;
  assign last   = (iter_q == LAST_ITER);
  assign addend = eff_addend(dir_i, atan_val_i);
  assign sum_w  = wide_sum(z_q, addend);

  // State register. Reset returns the block to IDLE.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Start (re)enters RUN from any state; the last iteration ends the run.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = RUN;
    end else if (step && last) begin
      state_d = IDLE;
    end
  end

  // Datapath and status next values: load on start, accumulate on step, otherwise hold.
  always_comb begin
    z_d    = z_q;
    iter_d = iter_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (start_i) begin
      z_d    = (ZERO_START != 0) ? '0 : z_init_i;
      iter_d = '0;
      ovf_d  = 1'b0;
    end else if (step) begin
      z_d   = sum_w[WIDTH-1:0];
      ovf_d = ovf_q | sum_ovf(z_q, addend, sum_w);
      if (last) begin
        done_d = 1'b1;
      end else begin
        iter_d = iter_q + CNT_W'(1);
      end
    end
  end

  // Datapath and status registers. Reset clears everything, including the angle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      z_q    <= '0;
      iter_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      z_q    <= z_d;
      iter_q <= iter_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // Outputs are taken from registers only; busy is decoded from the state register.
  always_comb begin
    z_o    = z_q;
    iter_o = iter_q;
    busy_o = (state_q == RUN);
    done_o = done_q;
    ovf_o  = ovf_q;
  end

endmodule

// File: tb/tb_cordic_angle_acc.sv
// Bench for cordic_angle_acc. Three instances share the input stimulus:
// k=0 has NITER=4 and ZERO_START=1, k=1 has NITER=4 and ZERO_START=0, and
// k=2 has NITER=1 and ZERO_START=0. A behavioural model tracks all three.
module tb_cordic_angle_acc;

  logic        clk;
  logic        rst, start, en, dir;
  logic [31:0] atan, zinit;

  logic [31:0] dz[3];
  logic [4:0]  diter[3];
  logic        dbusy[3], ddone[3], dovf[3];

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] mz[3];
  int          miter[3];
  bit          mbusy[3], mdone[3], movf[3];
  int          mn[3]  = '{4, 4, 1};
  bit          mzs[3] = '{1'b1, 1'b0, 1'b0};

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  cordic_angle_acc #(.WIDTH(32), .NITER(4), .CNT_W(5), .ZERO_START(1)) dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .en_i(en), .dir_i(dir),
    .atan_val_i(atan), .z_init_i(zinit), .z_o(dz[0]), .iter_o(diter[0]),
    .busy_o(dbusy[0]), .done_o(ddone[0]), .ovf_o(dovf[0]));

  cordic_angle_acc #(.WIDTH(32), .NITER(4), .CNT_W(5), .ZERO_START(0)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .en_i(en), .dir_i(dir),
    .atan_val_i(atan), .z_init_i(zinit), .z_o(dz[1]), .iter_o(diter[1]),
    .busy_o(dbusy[1]), .done_o(ddone[1]), .ovf_o(dovf[1]));

  cordic_angle_acc #(.WIDTH(32), .NITER(1), .CNT_W(5), .ZERO_START(0)) dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .en_i(en), .dir_i(dir),
    .atan_val_i(atan), .z_init_i(zinit), .z_o(dz[2]), .iter_o(diter[2]),
    .busy_o(dbusy[2]), .done_o(ddone[2]), .ovf_o(dovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: exact integer arithmetic, then a range check for overflow.
  task automatic model_edge();
    longint a, s;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mz[k] = '0; miter[k] = 0; mbusy[k] = 0; mdone[k] = 0; movf[k] = 0;
      end else if (start) begin
        mz[k] = mzs[k] ? 32'd0 : zinit;
        miter[k] = 0; movf[k] = 0; mdone[k] = 0; mbusy[k] = 1;
      end else if (mbusy[k] && en) begin
        a = longint'($signed(atan));
        if (!dir) a = -a;
        s = longint'($signed(mz[k])) + a;
        if (s > MAXV || s < MINV) movf[k] = 1;
        mz[k] = s[31:0];
        mdone[k] = 0;
        if (miter[k] == mn[k] - 1) begin
          mbusy[k] = 0; mdone[k] = 1;
        end else begin
          miter[k]++;
        end
      end else begin
        mdone[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; en = 1; dir = 1; atan = 32'h1234; zinit = 32'h55;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (dz[k] !== 32'd0) begin bad++; $display("FAIL reset_z k=%0d got=%h want=0", k, dz[k]); end
      total++; if (diter[k] !== 5'd0) begin bad++; $display("FAIL reset_iter k=%0d got=%0d want=0", k, diter[k]); end
      total++; if (dbusy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy k=%0d got=%b want=0", k, dbusy[k]); end
      total++; if (ddone[k] !== 1'b0) begin bad++; $display("FAIL reset_done k=%0d got=%b want=0", k, ddone[k]); end
      total++; if (dovf[k] !== 1'b0) begin bad++; $display("FAIL reset_ovf k=%0d got=%b want=0", k, dovf[k]); end
    end
    rst = 0; start = 0; en = 0;
  endtask

  task automatic test_vector();
    logic [31:0] at[4];
    bit          dr[4];
    at = '{32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4};
    dr = '{1'b1, 1'b0, 1'b1, 1'b1};
    zinit = $urandom; start = 1; en = 1;
    tick();
    start = 0;
    total++; if (dbusy[0] !== 1'b1 || dz[0] !== 32'd0 || diter[0] !== 5'd0) begin
      bad++; $display("FAIL vec_load busy=%b z=%h iter=%0d want busy=1 z=0 iter=0", dbusy[0], dz[0], diter[0]); end
    total++; if (dz[1] !== zinit) begin bad++; $display("FAIL vec_zinit got=%h want=%h", dz[1], zinit); end
    for (int i = 0; i < 4; i++) begin
      dir = dr[i]; atan = at[i]; en = 1;
      tick();
      if (i < 3) begin
        total++; if (ddone[0] !== 1'b0 || diter[0] !== 5'(i + 1)) begin
          bad++; $display("FAIL vec_step%0d done=%b iter=%0d want done=0 iter=%0d", i, ddone[0], diter[0], i + 1); end
      end
      if (i == 0) begin
        total++; if (ddone[2] !== 1'b1 || dz[2] !== zinit + 32'h20000000 || dbusy[2] !== 1'b0) begin
          bad++; $display("FAIL vec_n1 done=%b z=%h busy=%b want done=1 z=%h busy=0", ddone[2], dz[2], dbusy[2], zinit + 32'h20000000); end
      end
    end
    total++; if (dz[0] !== 32'h1C284511) begin bad++; $display("FAIL vec_z got=%h want=1c284511", dz[0]); end
    total++; if (ddone[0] !== 1'b1 || dbusy[0] !== 1'b0 || dovf[0] !== 1'b0 || diter[0] !== 5'd3) begin
      bad++; $display("FAIL vec_done done=%b busy=%b ovf=%b iter=%0d want 1 0 0 3", ddone[0], dbusy[0], dovf[0], diter[0]); end
    total++; if (dz[1] !== mz[1] || ddone[1] !== 1'b1) begin bad++; $display("FAIL vec_z1 got=%h want=%h", dz[1], mz[1]); end
    en = 0;
    tick();
    total++; if (ddone[0] !== 1'b0 || dz[0] !== 32'h1C284511) begin
      bad++; $display("FAIL vec_pulse done=%b z=%h want done=0 z=1c284511", ddone[0], dz[0]); end
  endtask

  task automatic test_overflow();
    zinit = 32'h7FFFFFFF; start = 1; en = 0;
    tick();
    start = 0; dir = 1; atan = 32'h1; en = 1;
    tick();
    total++; if (dz[1] !== 32'h80000000 || dovf[1] !== 1'b1) begin
      bad++; $display("FAIL ovf_set z=%h ovf=%b want z=80000000 ovf=1", dz[1], dovf[1]); end
    total++; if (dz[2] !== 32'h80000000 || dovf[2] !== 1'b1 || ddone[2] !== 1'b1) begin
      bad++; $display("FAIL ovf_n1 z=%h ovf=%b done=%b want 80000000 1 1", dz[2], dovf[2], ddone[2]); end
    total++; if (dz[0] !== 32'h1 || dovf[0] !== 1'b0) begin
      bad++; $display("FAIL ovf_none z=%h ovf=%b want z=1 ovf=0", dz[0], dovf[0]); end
    atan = 32'h0;
    tick(); tick();
    en = 0;
    tick();
    total++; if (dovf[1] !== 1'b1 || diter[1] !== 5'd3) begin
      bad++; $display("FAIL ovf_hold ovf=%b iter=%0d want ovf=1 iter=3", dovf[1], diter[1]); end
    // Subtract the most negative atan value: the effective addend is +2^31.
    start = 1;
    tick();
    start = 0; dir = 0; atan = 32'h80000000; en = 1;
    tick();
    total++; if (dovf[1] !== 1'b0 && dz[1] === 32'h7FFFFFFF) begin
      bad++; $display("FAIL ovf_clear ovf=%b want ovf=1 after min subtract", dovf[1]); end
    total++; if (dz[0] !== 32'h80000000 || dovf[0] !== 1'b1) begin
      bad++; $display("FAIL sub_min0 z=%h ovf=%b want 80000000 1", dz[0], dovf[0]); end
    total++; if (dz[1] !== 32'hFFFFFFFF || dovf[1] !== 1'b1) begin
      bad++; $display("FAIL sub_min1 z=%h ovf=%b want ffffffff 1", dz[1], dovf[1]); end
    zinit = 32'hFFFFFFFF; start = 1; en = 0;
    tick();
    total++; if (dovf[1] !== 1'b0) begin bad++; $display("FAIL ovf_restart ovf=%b want 0", dovf[1]); end
    start = 0; en = 1;
    tick();
    total++; if (dz[1] !== 32'h7FFFFFFF || dovf[1] !== 1'b0) begin
      bad++; $display("FAIL sub_min_ok z=%h ovf=%b want 7fffffff 0", dz[1], dovf[1]); end
    en = 0;
  endtask

  task automatic test_stall();
    bit          pat[7];
    logic [31:0] e0, e1;
    int          cnt;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    zinit = $urandom; start = 1; en = 0;
    tick();
    start = 0; e0 = 32'd0; e1 = zinit; cnt = 0;
    for (int i = 0; i < 7; i++) begin
      en = pat[i]; dir = $urandom_range(0, 1); atan = $urandom;
      if (pat[i]) begin
        e0 = dir ? e0 + atan : e0 - atan;
        e1 = dir ? e1 + atan : e1 - atan;
        cnt++;
      end
      tick();
      total++; if (diter[0] !== 5'(cnt < 4 ? cnt : 3) || ddone[0] !== (i == 6)) begin
        bad++; $display("FAIL stall_step%0d iter=%0d done=%b want iter=%0d done=%b", i, diter[0], ddone[0], cnt < 4 ? cnt : 3, i == 6); end
    end
    total++; if (dz[0] !== e0 || dz[1] !== e1) begin
      bad++; $display("FAIL stall_z z0=%h z1=%h want %h %h", dz[0], dz[1], e0, e1); end
    en = 0;
  endtask

  task automatic test_restart();
    zinit = $urandom; start = 1;
    tick();
    start = 0; en = 1; dir = 1; atan = 32'h01000000;
    tick(); tick();
    total++; if (diter[0] !== 5'd2) begin bad++; $display("FAIL rs_iter2 got=%0d want=2", diter[0]); end
    zinit = $urandom; start = 1; en = 1;
    tick();
    total++; if (diter[0] !== 5'd0 || dz[0] !== 32'd0 || dz[1] !== zinit) begin
      bad++; $display("FAIL rs_reload iter=%0d z0=%h z1=%h want 0 0 %h", diter[0], dz[0], dz[1], zinit); end
    total++; if (ddone[0] !== 1'b0 || dbusy[0] !== 1'b1 || ddone[2] !== 1'b0) begin
      bad++; $display("FAIL rs_nodone done=%b busy=%b done2=%b want 0 1 0", ddone[0], dbusy[0], ddone[2]); end
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (ddone[0] !== 1'b1 || dz[0] !== 32'h04000000) begin
      bad++; $display("FAIL rs_finish done=%b z=%h want 1 04000000", ddone[0], dz[0]); end
    en = 0;
  endtask

  task automatic test_reset_mid();
    zinit = 32'h7FFFFFFF; start = 1;
    tick();
    start = 0; en = 1; dir = 1; atan = 32'h7FFFFFFF;
    tick(); tick(); tick();
    total++; if (diter[0] !== 5'd3 || dbusy[0] !== 1'b1 || dovf[1] !== 1'b1) begin
      bad++; $display("FAIL rm_pre iter=%0d busy=%b ovf1=%b want 3 1 1", diter[0], dbusy[0], dovf[1]); end
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    for (int k = 0; k < 2; k++) begin
      total++; if (dz[k] !== 32'd0 || diter[k] !== 5'd0 || dbusy[k] !== 1'b0 || ddone[k] !== 1'b0 || dovf[k] !== 1'b0) begin
        bad++; $display("FAIL rm_clear k=%0d z=%h iter=%0d busy=%b done=%b ovf=%b want all 0", k, dz[k], diter[k], dbusy[k], ddone[k], dovf[k]); end
    end
    tick(); tick();
    total++; if (dz[0] !== 32'd0 || diter[0] !== 5'd0 || dbusy[0] !== 1'b0 || ddone[0] !== 1'b0) begin
      bad++; $display("FAIL rm_ignore z=%h iter=%0d busy=%b done=%b want all 0", dz[0], diter[0], dbusy[0], ddone[0]); end
    en = 0;
  endtask

  task automatic test_idle_en();
    logic [31:0] saved;
    start = 1;
    tick();
    start = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      dir = $urandom_range(0, 1); atan = $urandom;
      tick();
    end
    saved = mz[0];
    total++; if (ddone[0] !== 1'b1 || dz[0] !== saved) begin
      bad++; $display("FAIL idle_fin done=%b z=%h want 1 %h", ddone[0], dz[0], saved); end
    for (int i = 0; i < 3; i++) begin
      atan = $urandom;
      tick();
      total++; if (dz[0] !== saved || diter[0] !== 5'd3 || ddone[0] !== 1'b0) begin
        bad++; $display("FAIL idle_en%0d z=%h iter=%0d done=%b want %h 3 0", i, dz[0], diter[0], ddone[0], saved); end
    end
    en = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 9) < 7);
      dir   = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       atan = 32'h80000000;
        1:       atan = 32'h7FFFFFFF;
        default: atan = $urandom;
      endcase
      zinit = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFF0 : $urandom;
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (dz[k] !== mz[k] || diter[k] !== 5'(miter[k]) || dbusy[k] !== mbusy[k] ||
            ddone[k] !== mdone[k] || dovf[k] !== movf[k]) begin
          bad++;
          $display("FAIL rand c=%0d k=%0d got z=%h it=%0d b=%b d=%b o=%b want z=%h it=%0d b=%b d=%b o=%b",
                   c, k, dz[k], diter[k], dbusy[k], ddone[k], dovf[k],
                   mz[k], miter[k], mbusy[k], mdone[k], movf[k]);
        end
      end
    end
    rst = 0; start = 0; en = 0;
  endtask

  initial begin
    rst = 1; start = 0; en = 0; dir = 0; atan = '0; zinit = '0;
    for (int k = 0; k < 3; k++) begin
      mz[k] = '0; miter[k] = 0; mbusy[k] = 0; mdone[k] = 0; movf[k] = 0;
    end
    test_reset();
    test_vector();
    test_overflow();
    test_stall();
    test_restart();
    test_reset_mid();
    test_idle_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_angle_acc.md
CORDIC_ANGLE_ACC -- requirements
Module: cordic_angle_acc

Interface
REQ-001 Parameter WIDTH, default 32: angle word width, signed two's complement.
REQ-002 Parameter NITER, default 16: iterations per operation, legal range 1..2^CNT_W.
REQ-003 Parameter CNT_W, default 5: iteration counter width.
REQ-004 Parameter ZERO_START, default 1: start loads zero when 1; start loads z_init when 0.
REQ-005 Port clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port reset  input  1  reset, synchronous and active-high.
REQ-007 Port start  input  1  begin a new operation (load z, clear counter).
REQ-008 Port en  input  1  advance one iteration this cycle.
REQ-009 Port dir  input  1  1 = add atan_val, 0 = subtract atan_val.
REQ-010 Port atan_val  input  WIDTH  arctangent constant for the current iteration.
REQ-011 Port z_init  input  WIDTH  initial angle, used only when ZERO_START=0.
REQ-012 Port z  output  WIDTH  registered accumulated angle.
REQ-013 Port iter  output  CNT_W  registered current iteration index; addresses the atan ROM.
REQ-014 Port busy  output  1  operation in progress.
REQ-015 Port done  output  1  one-cycle pulse on completion.
REQ-016 Port ovf  output  1  sticky signed-overflow flag for the current operation.

Function
REQ-017 Two states: IDLE (busy=0) and RUN (busy=1).
REQ-018 start=1 in any state: z <= (ZERO_START ? 0 : z_init), iter <= 0, ovf <= 0, done <= 0, busy <= 1 on the next edge.
REQ-019 start=1 takes priority over en=1 in the same cycle; no iteration is performed that cycle.
REQ-020 A start issued in RUN aborts the current operation and restarts with no done pulse.
REQ-021 RUN with en=1 and start=0: z <= dir ? z+atan_val : z-atan_val, iter <= iter+1.
REQ-022 RUN with en=0: z, iter and ovf hold; stalls of any length are legal.
REQ-023 en is ignored in IDLE; z, iter and ovf hold.
REQ-024 Arithmetic is computed at WIDTH+1 bits; z takes the low WIDTH bits (wrap modulo 2^WIDTH, angle wrap is intended).
REQ-025 ovf is set when the operands have equal sign (after negating atan_val for subtract) and the result sign differs; it stays set until the next start or reset.
REQ-026 Completing the iteration with iter == NITER-1 leaves IDLE on the next edge: busy <= 0, done <= 1 for exactly one cycle.
REQ-027 After completion, iter holds NITER-1 and z holds the final angle until the next start.
REQ-028 Latency with en held high: start sampled at edge t, done=1 in the cycle following edge t+NITER.
REQ-029 For subtraction of atan_val = -2^(WIDTH-1), the result wraps and the overflow rule of REQ-025 applies to the effective addend; no special case.
REQ-030 For NITER=1, a single en completes the operation.

Reset
REQ-031 reset=1 at a rising edge: z=0, iter=0, busy=0, done=0, ovf=0, state IDLE.
REQ-032 reset has priority over start and en; reset mid-operation aborts with no done pulse.
REQ-033 All outputs are registered; none depend combinationally on inputs.

Verification
REQ-034 NITER=4, ZERO_START=1, en=1, dir=1,0,1,1, atan=0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4 -> z=0x1C284511, done one cycle after 4th iteration, ovf=0.
REQ-035 ZERO_START=0, z_init=0x7FFFFFFF, dir=1, atan=0x00000001 -> z=0x80000000, ovf=1 held until next start.
REQ-036 NITER=4, en toggled 1,0,0,1,1,0,1 -> iter advances only on en=1 cycles; done after 4th en=1; z equals the no-stall result.
REQ-037 start and en both high in RUN with iter=2 -> iter=0, z reloaded, no add, no done pulse.
REQ-038 reset asserted with iter=3 in RUN -> next cycle z=0, iter=0, busy=0, done=0, ovf=0; en then ignored.
REQ-039 en=1 while IDLE after done -> z and iter unchanged, no done pulse.
